// File: rtl/seg_capture.sv
// seg_capture: readback of a multiplexed 4-digit seven-segment bus.
// The synchronised {an_n, seg_n} must hold still for STABLE_CYCLES cycles.
// After that, the pattern on the selected digit is decoded into a hex
// nibble. Patterns that are not hex glyphs raise bad_glyph. frame_done
// pulses once every digit has been captured at least once.
// Optional decimal-point readback: define SEG_CAPTURE_DP_EN.
//
// state  | meaning
// SETTLE | waiting for the bus to stay unchanged long enough to capture
// HOLD   | pattern already captured; waiting for the bus to change
module seg_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  an_n,
    input  logic        clr,
`ifdef SEG_CAPTURE_DP_EN
    input  logic        dp_n,
    output logic [3:0]  dp_valid,
`endif
    output logic [15:0] value,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic        bad_glyph
);

`ifdef SEG_CAPTURE_DP_EN
    localparam int SW = 12;
`else
    localparam int SW = 11;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [0:0] {SETTLE = 1'b0, HOLD = 1'b1} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_capture;

    logic [SW-1:0]    w_in;
    logic [SW-1:0]    r_sync1;
    logic [SW-1:0]    r_sync2;
    logic [SW-1:0]    r_prev;
    logic             w_same;

    logic [3:0]       r_seen;
    logic [3:0]       w_sel;
    logic             w_onehot;
    logic [1:0]       w_idx;
    logic [6:0]       w_lit;
    logic [4:0]       w_dec;

`ifdef SEG_CAPTURE_DP_EN
    assign w_in = {dp_n, an_n, seg_n};
`else
    assign w_in = {an_n, seg_n};
`endif

    assign w_same   = (r_sync2 == r_prev);
    assign w_sel    = ~r_sync2[10:7];
    assign w_lit    = ~r_sync2[6:0];
    assign w_onehot = (w_sel != 4'd0) && ((w_sel & (w_sel - 4'd1)) == 4'd0);

    // Map lit segments abcdefg to {hit, code}; hit=0 means not a hex glyph.
    function automatic logic [4:0] decode_glyph(input logic [6:0] lit);
        logic [4:0] res;
        case (lit)
            7'b1111110: res = 5'h10;
            7'b0110000: res = 5'h11;
            7'b1101101: res = 5'h12;
            7'b1111001: res = 5'h13;
            7'b0110011: res = 5'h14;
            7'b1011011: res = 5'h15;
            7'b1011111: res = 5'h16;
            7'b1110000: res = 5'h17;
            7'b1111111: res = 5'h18;
            7'b1111011: res = 5'h19;
            7'b1110111: res = 5'h1A;
            7'b0011111: res = 5'h1B;
            7'b1001110: res = 5'h1C;
            7'b0111101: res = 5'h1D;
            7'b1001111: res = 5'h1E;
            7'b1000111: res = 5'h1F;
            default:    res = 5'h00;
        endcase
        return res;
    endfunction

    assign w_dec = decode_glyph(w_lit);

    // Digit index of the single selected anode (only used when one-hot).
    always_comb begin
        w_idx = 2'd0;
        case (w_sel)
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    // Two-flop synchroniser followed by the compare register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= w_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // FSM state and stability counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SETTLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, counter, and the one-cycle capture strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            SETTLE: begin
                if (!w_same) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt >= CNT_LAST) begin
                    w_capture   = 1'b1;
                    w_state_nxt = HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (!w_same) begin
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = SETTLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // clr wins over a capture due on the same edge
        if (clr) begin
            w_state_nxt = SETTLE;
            w_cnt_nxt   = '0;
            w_capture   = 1'b0;
        end
    end

    // Capture datapath: nibbles, valid bits, seen mask and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value       <= '0;
            digit_valid <= '0;
            r_seen      <= '0;
            frame_done  <= 1'b0;
            bad_glyph   <= 1'b0;
`ifdef SEG_CAPTURE_DP_EN
            dp_valid    <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            bad_glyph  <= 1'b0;
            if (clr) begin
                value       <= '0;
                digit_valid <= '0;
                r_seen      <= '0;
`ifdef SEG_CAPTURE_DP_EN
                dp_valid    <= '0;
`endif
            end else if (w_capture && w_onehot) begin
                if (w_lit == 7'd0) begin
                    digit_valid[w_idx] <= 1'b0;
                end else if (w_dec[4]) begin
                    value[w_idx*4 +: 4] <= w_dec[3:0];
                    digit_valid[w_idx]  <= 1'b1;
                end else begin
                    digit_valid[w_idx] <= 1'b0;
                    bad_glyph          <= 1'b1;
                end
                if ((r_seen | w_sel) == 4'hF) begin
                    frame_done <= 1'b1;
                    r_seen     <= '0;
                end else begin
                    r_seen <= r_seen | w_sel;
                end
`ifdef SEG_CAPTURE_DP_EN
                dp_valid[w_idx] <= ~r_sync2[11];
`endif
            end
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture (STABLE_CYCLES=4, default build).
module tb_seg_capture;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        clr;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        bad_glyph;

    int n_cmp = 0;
    int n_err = 0;
    int n_fd  = 0;
    int n_bg  = 0;
    int fd0, bg0;

    seg_capture #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .clr         (clr),
        .value       (value),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .bad_glyph   (bad_glyph)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (frame_done === 1'b1) n_fd++;
        if (bad_glyph === 1'b1)  n_bg++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input logic [3:0] an, input logic [6:0] lit);
        an_n  = an;
        seg_n = ~lit;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clr   = 1'b0;
        show(4'b1111, 7'b0000000);
        step(3);
        n_cmp++;
        if ({value, digit_valid, frame_done, bad_glyph} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got value=%h dv=%b fd=%b bg=%b want all 0",
                     value, digit_valid, frame_done, bad_glyph);
        end
        #2 rst_n = 1'b1;
        step(3);
    endtask

    task automatic test_single_digit;
        fd0 = n_fd; bg0 = n_bg;
        show(4'b1110, 7'b0110000);
        step(6);
        n_cmp++;
        if (digit_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL single_early: dv=%b want 0000 at edge 6", digit_valid);
        end
        step(1);
        n_cmp++;
        if (value !== 16'h0001 || digit_valid !== 4'b0001) begin
            n_err++;
            $display("FAIL single_edge7: value=%h dv=%b want 0001/0001", value, digit_valid);
        end
        n_cmp++;
        if (frame_done !== 1'b0 || bad_glyph !== 1'b0) begin
            n_err++;
            $display("FAIL single_pulses: fd=%b bg=%b want 0/0", frame_done, bad_glyph);
        end
        step(3);
        n_cmp++;
        if (n_fd != fd0 || n_bg != bg0) begin
            n_err++;
            $display("FAIL single_pulse_count: fd=%0d bg=%0d want 0/0", n_fd - fd0, n_bg - bg0);
        end
    endtask

    task automatic test_scan;
        fd0 = n_fd; bg0 = n_bg;
        show(4'b1110, 7'b1101101); step(10);
        show(4'b1101, 7'b1110111); step(10);
        show(4'b1011, 7'b0011111); step(10);
        show(4'b0111, 7'b1000111); step(6);
        n_cmp++;
        if (frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL scan_fd_early: fd=%b want 0", frame_done);
        end
        step(1);
        n_cmp++;
        if (frame_done !== 1'b1) begin
            n_err++;
            $display("FAIL scan_fd_pulse: fd=%b want 1", frame_done);
        end
        step(3);
        n_cmp++;
        if (value !== 16'hFBA2 || digit_valid !== 4'b1111) begin
            n_err++;
            $display("FAIL scan_value: value=%h dv=%b want FBA2/1111", value, digit_valid);
        end
        n_cmp++;
        if (n_fd - fd0 != 1 || n_bg != bg0) begin
            n_err++;
            $display("FAIL scan_pulse_count: fd=%0d bg=%0d want 1/0", n_fd - fd0, n_bg - bg0);
        end
    endtask

    task automatic test_bad_glyph;
        fd0 = n_fd; bg0 = n_bg;
        show(4'b1101, 7'b1010101);
        step(7);
        n_cmp++;
        if (bad_glyph !== 1'b1) begin
            n_err++;
            $display("FAIL bad_pulse: bg=%b want 1", bad_glyph);
        end
        step(3);
        n_cmp++;
        if (value !== 16'hFBA2 || digit_valid !== 4'b1101) begin
            n_err++;
            $display("FAIL bad_state: value=%h dv=%b want FBA2/1101", value, digit_valid);
        end
        n_cmp++;
        if (n_bg - bg0 != 1 || n_fd != fd0) begin
            n_err++;
            $display("FAIL bad_pulse_count: bg=%0d fd=%0d want 1/0", n_bg - bg0, n_fd - fd0);
        end
    endtask

    task automatic test_unstable;
        fd0 = n_fd; bg0 = n_bg;
        for (int i = 0; i < 10; i++) begin
            show(4'b1011, (i % 2 == 0) ? 7'b1111110 : 7'b1111111);
            step(3);
        end
        n_cmp++;
        if (value !== 16'hFBA2 || digit_valid !== 4'b1101 || n_fd != fd0 || n_bg != bg0) begin
            n_err++;
            $display("FAIL unstable: value=%h dv=%b fd=%0d bg=%0d want FBA2/1101/0/0",
                     value, digit_valid, n_fd - fd0, n_bg - bg0);
        end
    endtask

    task automatic test_no_select;
        fd0 = n_fd; bg0 = n_bg;
        show(4'b1100, 7'b1111111);
        step(20);
        n_cmp++;
        if (value !== 16'hFBA2 || digit_valid !== 4'b1101 || n_fd != fd0 || n_bg != bg0) begin
            n_err++;
            $display("FAIL two_digits: value=%h dv=%b fd=%0d bg=%0d want FBA2/1101/0/0",
                     value, digit_valid, n_fd - fd0, n_bg - bg0);
        end
        show(4'b1111, 7'b1010101);
        step(20);
        n_cmp++;
        if (value !== 16'hFBA2 || digit_valid !== 4'b1101 || n_fd != fd0 || n_bg != bg0) begin
            n_err++;
            $display("FAIL no_digit: value=%h dv=%b fd=%0d bg=%0d want FBA2/1101/0/0",
                     value, digit_valid, n_fd - fd0, n_bg - bg0);
        end
    endtask

    task automatic test_clr;
        fd0 = n_fd; bg0 = n_bg;
        show(4'b0111, 7'b1011011);
        step(6);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        n_cmp++;
        if (value !== 16'h0000 || digit_valid !== 4'b0000 || frame_done !== 1'b0 || bad_glyph !== 1'b0) begin
            n_err++;
            $display("FAIL clr_edge: value=%h dv=%b fd=%b bg=%b want 0000/0000/0/0",
                     value, digit_valid, frame_done, bad_glyph);
        end
        step(4);
        n_cmp++;
        if (value !== 16'h5000 || digit_valid !== 4'b1000) begin
            n_err++;
            $display("FAIL clr_recapture: value=%h dv=%b want 5000/1000", value, digit_valid);
        end
        // seen must have been cleared: digits 3,0,2 alone must not complete a frame
        show(4'b1110, 7'b1111110); step(10);
        show(4'b1011, 7'b1111111); step(10);
        n_cmp++;
        if (value !== 16'h5800 || digit_valid !== 4'b1101 || n_fd != fd0 || n_bg != bg0) begin
            n_err++;
            $display("FAIL clr_seen: value=%h dv=%b fd=%0d bg=%0d want 5800/1101/0/0",
                     value, digit_valid, n_fd - fd0, n_bg - bg0);
        end
    endtask

    task automatic test_async_reset;
        show(4'b1110, 7'b1110000);
        step(3);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({value, digit_valid, frame_done, bad_glyph} !== 22'd0) begin
            n_err++;
            $display("FAIL async_reset: value=%h dv=%b fd=%b bg=%b want all 0",
                     value, digit_valid, frame_done, bad_glyph);
        end
        step(2);
        #2 rst_n = 1'b1;
        step(1);
        n_cmp++;
        if (value !== 16'h0000 || digit_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL after_release: value=%h dv=%b want 0000/0000", value, digit_valid);
        end
        step(10);
        n_cmp++;
        if (value !== 16'h0007 || digit_valid !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_recapture: value=%h dv=%b want 0007/0001", value, digit_valid);
        end
    endtask

    initial begin
        test_reset;
        test_single_digit;
        test_scan;
        test_bad_glyph;
        test_unstable;
        test_no_select;
        test_clr;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg_capture.md
Name: seg_capture

Overview:
- Reads back a multiplexed 4-digit seven-segment display bus (active-low segment cathodes a..g, active-low anodes).
- Recovers the 4-bit hex code shown on each digit.
- Used as the readback/self-check end of the display path: the bench or a host compares the recovered value against what the display logic was asked to show.
- Flags glyphs that are not valid hex patterns.

Parameters:
- STABLE_CYCLES, 4, consecutive cycles the synchronised {an_n, seg_n} must stay unchanged before a capture; legal range 2..255.
- CNT_W, 8, width of the stability counter; must hold STABLE_CYCLES.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- seg_n  input  7  segment cathodes, active-low; bit6=a, bit5=b … bit0=g
- an_n  input  4  digit anodes, active-low; bit k selects digit k (digit 0 = rightmost)
- clr  input  1  synchronous clear of captured state
- value  output  16  recovered codes; digit k in value[4k+3:4k]
- digit_valid  output  4  bit k=1: value nibble k holds a decoded glyph
- frame_done  output  1  one-cycle pulse when all 4 digits have been captured since the last pulse/clear
- bad_glyph  output  1  one-cycle pulse when a captured pattern is not in the glyph table

Behaviour:
- Reset (rst_n=0, async):
  - value=0, digit_valid=0, frame_done=0, bad_glyph=0.
  - Synchronisers, stability counter and seen mask are cleared.
  - FSM enters SETTLE.
- Inputs: seg_n and an_n each pass through a 2-flop synchroniser, then one compare register (prev).
- FSM:
  - SETTLE: counter increments (saturating) while sync==prev. Any difference resets the counter to 0 and keeps the FSM in SETTLE. When the counter reaches STABLE_CYCLES-1 with sync==prev, perform a capture and go to HOLD.
  - HOLD: no further captures. Any difference goes to SETTLE with counter=0.
  - One capture per stable period.
- Capture rules, with lit = ~seg_n:
  - an_n not exactly one-hot-low (no digit or more than one digit selected): no update, no pulse.
  - lit == 0000000 (blank): digit_valid[k]=0, nibble unchanged, seen[k]=1, no bad_glyph.
  - lit in table: nibble k=code, digit_valid[k]=1, seen[k]=1.
  - Otherwise: bad_glyph pulses, digit_valid[k]=0, nibble unchanged, seen[k]=1.
- Glyph table, lit abcdefg -> code:
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3
  - 0110011→4, 1011011→5, 1011111→6, 1110000→7
  - 1111111→8, 1111011→9, 1110111→A, 0011111→b
  - 1001110→C, 0111101→d, 1001111→E, 1000111→F
- Latency: outputs update on edge STABLE_CYCLES+3 after the input settles, counting the first edge that samples the new value as edge 1.
- frame_done:
  - Asserts on the edge where seen becomes 1111; seen returns to 0000 the same edge.
  - If the capture that completes seen is a bad glyph, frame_done and bad_glyph pulse together.
- clr (synchronous, highest priority after reset):
  - Clears value, digit_valid, seen and the counter, and forces SETTLE.
  - A capture due on the same edge is discarded and no pulses are issued.
- The counter saturates at STABLE_CYCLES-1; it never wraps during long stable periods.
- rst_n asserted mid-capture: all state is cleared immediately. No partial update is visible after release.

Optional Feature:
- SEG_CAPTURE_DP_EN defined:
  - Adds input dp_n (1, active-low decimal point), synchronised and included in the stability compare.
  - Adds output dp_valid (4): bit k is set to ~dp_n on every one-hot capture of digit k (including blank and bad glyphs) and cleared by reset/clr.
  - dp_n is ignored by the glyph table.
- Undefined: no dp_n/dp_valid ports; behaviour otherwise identical.

Test Plan:
- Reset, then hold an_n=1110, seg_n=~7'b0110000 steady → on edge 7 (STABLE_CYCLES=4): value[3:0]=1, digit_valid=0001, no other pulses.
- Scan digits 0..3 with glyphs 2,A,b,F, each held 10 cycles → value=16'hFBA2, digit_valid=1111, frame_done one pulse on the 4th capture.
- Digit 1 shows lit=1010101 → bad_glyph one pulse, digit_valid[1]=0, value[7:4] unchanged.
- Toggle seg_n every 3 cycles (never stable for 4) → no captures, no pulses.
- an_n=1100 or 1111, stable for 20 cycles → no updates, no pulses.
- Assert clr on the edge a capture is due → value=0, digit_valid=0, no pulses; assert rst_n=0 mid-settle → all outputs 0 asynchronously.
